audio_looper_multi: RTL and testbench
=====================================

AUDIO_LOOPER_MULTI -- requirements
Module: audio_looper_multi

Interface
REQ-001 Parameter WIDTH, default 24: sample width per channel, signed two's complement.
REQ-002 Parameter ADDR_W, default 14: loop memory address width; DEPTH = 2^ADDR_W samples per channel.
REQ-003 Parameter CHANNELS, default 2: number of audio channels; channel k occupies bits [k*WIDTH +: WIDTH] of every packed bus.
REQ-004 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port btn, input, 1: record/play control level, already synchronised to clk; the block edge-detects it internally.
REQ-007 Port sample_valid, input, 1: one-cycle strobe per codec sample period.
REQ-008 Port in_data, input, CHANNELS*WIDTH: codec input samples, valid when sample_valid is high.
REQ-009 Port reverse, input, 1: playback direction; 1 = backward.
REQ-010 Port overdub, input, 1: 1 = in PLAY, mix input into the loop.
REQ-011 Port out_data, output, CHANNELS*WIDTH: registered output samples to the codec.
REQ-012 Port state, output, 2: current state; IDLE=0, RECORD=1, PLAY=2.
REQ-013 Port loop_len, output, ADDR_W+1: number of samples in the stored loop.

Function
REQ-014 The FSM SHALL have states IDLE, RECORD and PLAY; a btn rising edge (btn=1 now, 0 in the previous cycle) SHALL advance IDLE->RECORD->PLAY->IDLE.
REQ-015 Entering RECORD SHALL clear wr_addr to 0, and loop_len SHALL read 0 during RECORD.
REQ-016 In RECORD, each accepted sample_valid SHALL write all CHANNELS samples of in_data to mem[wr_addr] and increment wr_addr.
REQ-017 On RECORD->PLAY, loop_len SHALL be loaded with the number of samples written; if that count is 0, the FSM SHALL go to IDLE instead.
REQ-018 A write that makes the count equal DEPTH SHALL force RECORD->PLAY in the same edge with loop_len=DEPTH; no write SHALL wrap over sample 0.
REQ-019 If a btn edge and sample_valid coincide in RECORD, the sample SHALL be written and counted before the transition takes effect.
REQ-020 In IDLE and RECORD, out_data SHALL load in_data one cycle after each accepted sample_valid (registered passthrough).
REQ-021 Memory read SHALL be synchronous with 1-cycle latency; q = mem[play_addr] is continuously prefetched.
REQ-022 On entering PLAY, play_addr SHALL be 0 if reverse=0 and loop_len-1 if reverse=1.
REQ-023 In PLAY, each accepted sample_valid SHALL load out_data with q, then step play_addr.
REQ-024 Forward stepping SHALL wrap loop_len-1 -> 0; reverse stepping SHALL wrap 0 -> loop_len-1.
REQ-025 A reverse change mid-PLAY SHALL alter only the direction of the next step, with no address jump.
REQ-026 If overdub=1 in PLAY, the accepted sample SHALL also write mem[play_addr] <= sat(q + in_data) per channel, where sat clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-027 The block SHALL ignore sample_valid in the cycle immediately after an accepted one, so the prefetch is always valid.
REQ-028 A btn edge in PLAY SHALL go to IDLE with loop_len retained; IDLE->RECORD then overwrites the loop.

Reset
REQ-029 While reset=1: state=IDLE, wr_addr=0, play_addr=0, loop_len=0, out_data=0, edge-detect register=0.
REQ-030 Loop memory contents SHALL be unaffected by reset.
REQ-031 Reset SHALL take priority over btn and sample_valid in the same cycle.
REQ-032 Reset during RECORD or PLAY SHALL abandon the loop: loop_len=0 and state=IDLE on the next cycle.

Verification (WIDTH=24, ADDR_W=3, CHANNELS=2)
REQ-033 Scenario 1: reset, then sample_valid with in_data={24'h000010, 24'h000020} -> next cycle out_data={24'h000010, 24'h000020}, state=0.
REQ-034 Scenario 2: btn edge, 3 samples (ch0 = 1, 2, 3), btn edge -> loop_len=3, state=2; next 4 sample_valids give out_data ch0 = 1, 2, 3, 1.
REQ-035 Scenario 3: as Scenario 2 but reverse=1 at entry to PLAY -> ch0 sequence 3, 2, 1, 3; toggling reverse to 0 after the output 2 gives a next output of 3.
REQ-036 Scenario 4: record 10 samples without a btn edge -> after the 8th write state=2 and loop_len=8; samples 9 and 10 go through PLAY output only.
REQ-037 Scenario 5: overdub=1, loop ch0=24'h7FFFF0, input 24'h000020 -> the next pass outputs 24'h7FFFFF (saturated); input 24'h800000 on loop 24'hFFFFFF gives 24'h800000.
REQ-038 Scenario 6: btn edge coincident with sample_valid in RECORD after 2 writes -> loop_len=3; btn-btn with no samples -> state returns to 0 and loop_len=0.

Source files
------------

// File: rtl/audio_looper_multi.sv
`default_nettype none
// ============================================================================
// audio_looper_multi : multi-channel record / play / overdub looper with reverse
// Revision: 1.0
// ============================================================================
module audio_looper_multi #(
    parameter int WIDTH    = 24,
    parameter int ADDR_W   = 14,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn,
    input  logic                      sample_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      reverse,
    input  logic                      overdub,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [1:0]                state,
    output logic [ADDR_W:0]           loop_len
);

    localparam int              c_depth     = 1 << ADDR_W;
    localparam int              c_bus_w     = CHANNELS * WIDTH;
    localparam logic [1:0]      c_st_idle   = 2'd0;
    localparam logic [1:0]      c_st_record = 2'd1;
    localparam logic [1:0]      c_st_play   = 2'd2;
    localparam logic [ADDR_W:0] c_full      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] c_one     = ADDR_W'(1);

    logic [c_bus_w-1:0] r_mem [c_depth];
    logic [c_bus_w-1:0] r_q;
    logic [c_bus_w-1:0] r_out;
    logic [1:0]         r_state;
    logic               r_btn_d;
    logic               r_skip;
    logic [ADDR_W:0]    r_wr_addr;
    logic [ADDR_W-1:0]  r_play_addr;
    logic [ADDR_W:0]    r_loop_len;

    logic               w_accept;
    logic               w_edge;
    logic [ADDR_W:0]    w_count;
    logic [ADDR_W-1:0]  w_entry_addr;
    logic [ADDR_W-1:0]  w_last;
    logic [ADDR_W-1:0]  w_play_next;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [c_bus_w-1:0] w_wdata;
    logic [c_bus_w-1:0] w_mix;

    assign w_accept     = sample_valid & ~r_skip;
    assign w_edge       = btn & ~r_btn_d;
    assign w_count      = r_wr_addr + {{ADDR_W{1'b0}}, w_accept};
    assign w_entry_addr = reverse ? (w_count[ADDR_W-1:0] - c_one) : '0;
    assign w_last       = r_loop_len[ADDR_W-1:0] - c_one;

    // Per-channel saturating mix of the prefetched loop sample with the input
    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_chan
            logic [WIDTH:0] w_sum;
            assign w_sum = {r_q[g*WIDTH+WIDTH-1], r_q[g*WIDTH +: WIDTH]}
                         + {in_data[g*WIDTH+WIDTH-1], in_data[g*WIDTH +: WIDTH]};
            assign w_mix[g*WIDTH +: WIDTH] =
                (w_sum[WIDTH] == w_sum[WIDTH-1]) ? w_sum[WIDTH-1:0] :
                (w_sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
        end
    endgenerate

    // Write port and next play address; the read is aimed at the address the
    // player will hold next cycle so q is fresh even right after PLAY entry.
    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_play_addr;
        w_wdata     = w_mix;
        w_play_next = r_play_addr;
        if (!reset) begin
            case (r_state)
                c_st_record: begin
                    if (w_accept) begin
                        w_we    = 1'b1;
                        w_waddr = r_wr_addr[ADDR_W-1:0];
                        w_wdata = in_data;
                    end
                    if (w_count == c_full || (w_edge && w_count != '0))
                        w_play_next = w_entry_addr;
                end
                c_st_play: begin
                    if (w_accept) begin
                        w_we = overdub;
                        if (reverse)
                            w_play_next = (r_play_addr == '0) ? w_last : r_play_addr - c_one;
                        else
                            w_play_next = (r_play_addr == w_last) ? '0 : r_play_addr + c_one;
                    end
                end
                default: ;
            endcase
        end else begin
            w_play_next = '0;
        end
    end

    // Loop memory is deliberately outside reset; same-address write forwards
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        if (w_we && w_waddr == w_play_next)
            r_q <= w_wdata;
        else
            r_q <= r_mem[w_play_next];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_wr_addr   <= '0;
            r_play_addr <= '0;
            r_loop_len  <= '0;
            r_out       <= '0;
            r_btn_d     <= 1'b0;
            r_skip      <= 1'b0;
        end else begin
            r_btn_d     <= btn;
            r_skip      <= w_accept;
            r_play_addr <= w_play_next;
            case (r_state)
                c_st_idle: begin
                    if (w_accept)
                        r_out <= in_data;
                    if (w_edge) begin
                        r_state    <= c_st_record;
                        r_wr_addr  <= '0;
                        r_loop_len <= '0;
                    end
                end
                c_st_record: begin
                    if (w_accept) begin
                        r_out     <= in_data;
                        r_wr_addr <= w_count;
                    end
                    if (w_count == c_full) begin
                        r_state    <= c_st_play;
                        r_loop_len <= c_full;
                    end else if (w_edge) begin
                        if (w_count == '0) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_state    <= c_st_play;
                            r_loop_len <= w_count;
                        end
                    end
                end
                c_st_play: begin
                    if (w_accept)
                        r_out <= r_q;
                    if (w_edge)
                        r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign out_data = r_out;
    assign state    = r_state;
    assign loop_len = r_loop_len;

endmodule
`default_nettype wire

// File: tb/tb_audio_looper_multi.sv
`default_nettype none
// Bench for audio_looper_multi: directed scenarios with literal expectations,
// then random stimulus compared every cycle against a behavioural loop model.
module tb_audio_looper_multi;

    localparam int WIDTH    = 24;
    localparam int ADDR_W   = 3;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 8;
    localparam int BW       = WIDTH * CHANNELS;

    logic              clk = 1'b0;
    logic              reset;
    logic              btn;
    logic              sample_valid;
    logic [BW-1:0]     in_data;
    logic              reverse;
    logic              overdub;
    logic [BW-1:0]     out_data;
    logic [1:0]        state;
    logic [ADDR_W:0]   loop_len;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    audio_looper_multi #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .sample_valid (sample_valid),
        .in_data      (in_data),
        .reverse      (reverse),
        .overdub      (overdub),
        .out_data     (out_data),
        .state        (state),
        .loop_len     (loop_len)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] sat_mix(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW-1:0] r;
        longint        s;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            s = longint'($signed(a[k*WIDTH +: WIDTH])) + longint'($signed(b[k*WIDTH +: WIDTH]));
            if (s > 64'sd8388607)       s = 64'sd8388607;
            else if (s < -64'sd8388608) s = -64'sd8388608;
            r[k*WIDTH +: WIDTH] = WIDTH'(s);
        end
        return r;
    endfunction

    // Behavioural model: loop is an array, recording appends, playback walks
    // a position modulo the loop length.
    logic [BW-1:0] m_mem [DEPTH];
    logic [BW-1:0] m_out;
    int            m_state, m_len, m_rec, m_pos;
    bit            m_btnp, m_lacc, m_armed;

    initial begin
        bit acc, edg;
        m_armed = 0; m_state = 0; m_len = 0; m_rec = 0; m_pos = 0;
        m_out = '0; m_btnp = 0; m_lacc = 0;
        forever begin
            @(negedge clk);
            if (m_armed) begin
                check("out_data", out_data, m_out);
                check("state", state, m_state);
                check("loop_len", loop_len, m_len);
            end
            if (reset) begin
                m_state = 0; m_len = 0; m_out = '0; m_btnp = 0; m_lacc = 0;
                m_rec = 0; m_pos = 0; m_armed = 1;
            end else begin
                acc = sample_valid && !m_lacc;
                edg = btn && !m_btnp;
                case (m_state)
                    0: begin
                        if (acc) m_out = in_data;
                        if (edg) begin m_state = 1; m_rec = 0; m_len = 0; end
                    end
                    1: begin
                        if (acc) begin
                            m_mem[m_rec] = in_data;
                            m_rec++;
                            m_out = in_data;
                        end
                        if (m_rec == DEPTH || (edg && m_rec > 0)) begin
                            m_state = 2;
                            m_len   = m_rec;
                            m_pos   = reverse ? m_rec - 1 : 0;
                        end else if (edg) begin
                            m_state = 0;
                        end
                    end
                    default: begin
                        if (acc) begin
                            m_out = m_mem[m_pos];
                            if (overdub) m_mem[m_pos] = sat_mix(m_mem[m_pos], in_data);
                            m_pos = reverse ? (m_pos + m_len - 1) % m_len : (m_pos + 1) % m_len;
                        end
                        if (edg) m_state = 0;
                    end
                endcase
                m_btnp = btn;
                m_lacc = acc;
            end
        end
    end

    // Inputs change 2 time units after each rising edge
    task automatic cyc(input logic b, input logic sv, input logic [BW-1:0] d);
        btn = b; sample_valid = sv; in_data = d;
        @(posedge clk); #2;
    endtask

    task automatic samp(input logic [BW-1:0] d, output logic [BW-1:0] o);
        cyc(1'b0, 1'b1, d);
        o = out_data;
        cyc(1'b0, 1'b0, d);
    endtask

    task automatic press();
        cyc(1'b1, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
    endtask

    function automatic logic [WIDTH-1:0] rnd_sample();
        case ($urandom_range(0, 3))
            0: return WIDTH'($urandom);
            1: return 24'h7FFFF0 + WIDTH'($urandom_range(0, 15));
            2: return 24'h800000 + WIDTH'($urandom_range(0, 15));
            default: return WIDTH'($urandom_range(0, 63)) - 24'd32;
        endcase
    endfunction

    initial begin
        logic [BW-1:0] o;
        logic [BW-1:0] d;
        logic          b_lvl;
        int            e2 [4] = '{1, 2, 3, 1};
        int            e3 [4] = '{3, 2, 1, 3};

        reset = 1'b1; btn = 1'b0; sample_valid = 1'b0; in_data = '0;
        reverse = 1'b0; overdub = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        check("reset out_data", out_data, 0);
        check("reset state", state, 0);
        check("reset loop_len", loop_len, 0);
        reset = 1'b0;

        // Scenario 1: passthrough in IDLE
        cyc(1'b0, 1'b1, 48'h000010_000020);
        check("s1 passthrough", out_data, 48'h000010000020);
        check("s1 state", state, 0);
        cyc(1'b0, 1'b0, '0);

        // Scenario 2: record 1,2,3 and play forward
        press();
        check("s2 record state", state, 1);
        check("s2 record len", loop_len, 0);
        for (int i = 1; i <= 3; i++) samp({24'h000100, WIDTH'(i)}, o);
        press();
        check("s2 play state", state, 2);
        check("s2 play len", loop_len, 3);
        for (int j = 0; j < 4; j++) begin
            samp('0, o);
            check("s2 fwd ch0", o[WIDTH-1:0], e2[j]);
        end
        press();
        check("s2 idle state", state, 0);
        check("s2 len kept", loop_len, 3);

        // Scenario 3: reverse playback, then direction change
        press();
        for (int i = 1; i <= 3; i++) samp({24'h000200, WIDTH'(i)}, o);
        reverse = 1'b1;
        press();
        for (int j = 0; j < 4; j++) begin
            samp('0, o);
            check("s3 rev ch0", o[WIDTH-1:0], e3[j]);
        end
        reverse = 1'b0;
        samp('0, o);
        check("s3 toggle out", o[WIDTH-1:0], 2);
        samp('0, o);
        check("s3 after toggle", o[WIDTH-1:0], 3);
        press();

        // Scenario 6: btn coincident with a sample; empty record
        press();
        samp({24'h0, 24'd5}, o);
        samp({24'h0, 24'd6}, o);
        cyc(1'b1, 1'b1, {24'h0, 24'd7});
        cyc(1'b0, 1'b0, '0);
        check("s6 coincident len", loop_len, 3);
        check("s6 coincident state", state, 2);
        press();
        press();
        press();
        check("s6 empty state", state, 0);
        check("s6 empty len", loop_len, 0);

        // Scenario 4: memory full forces PLAY
        press();
        for (int i = 0; i < 10; i++) begin
            samp({24'h0, WIDTH'(16 + i)}, o);
            if (i == 7) begin
                check("s4 full state", state, 2);
                check("s4 full len", loop_len, 8);
            end
            if (i == 8) check("s4 play 9", o[WIDTH-1:0], 16);
            if (i == 9) check("s4 play 10", o[WIDTH-1:0], 17);
        end
        press();

        // Scenario 5: saturating overdub on a one-sample loop
        press();
        samp({24'hFFFFFF, 24'h7FFFF0}, o);
        press();
        overdub = 1'b1;
        samp({24'h800000, 24'h000020}, o);
        check("s5 first pass", o, 48'hFFFFFF7FFFF0);
        overdub = 1'b0;
        samp('0, o);
        check("s5 saturated", o, 48'h8000007FFFFF);
        press();

        // Random phase, checked by the per-cycle model comparison
        b_lvl = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < CHANNELS; k++) d[k*WIDTH +: WIDTH] = rnd_sample();
            if ($urandom_range(0, 14) == 0) b_lvl = ~b_lvl;
            if ($urandom_range(0, 59) == 0) reverse = ~reverse;
            if ($urandom_range(0, 39) == 0) overdub = ~overdub;
            reset = ($urandom_range(0, 699) == 0);
            cyc(b_lvl, ($urandom_range(0, 2) == 0), d);
        end
        reset = 1'b0;
        cyc(1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
